wt_rom_arbiter: RTL and testbench
=================================

WT_ROM_ARBITER -- requirements
Module: wt_rom_arbiter

Interface
REQ-001 Parameter AddrWidth, 9, weight ROM address width.
REQ-002 Parameter DataWidth, 192, weight ROM word width.
REQ-003 Parameter LenWidth, 4, burst length field width; field value is beats minus one.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 Req0_i  input  1  requester 0 (convolution) burst request, held until Gnt0_o.
REQ-007 Addr0_i  input  AddrWidth  requester 0 burst base address.
REQ-008 Len0_i  input  LenWidth  requester 0 burst length minus one.
REQ-009 Gnt0_o  output  1  requester 0 owns the ROM this cycle (address issue cycles).
REQ-010 RdValid0_o  output  1  RdData_o holds a requester 0 beat.
REQ-011 RdLast0_o  output  1  final beat of the requester 0 burst.
REQ-012 Req1_i, Addr1_i, Len1_i, Gnt1_o, RdValid1_o, RdLast1_o: same as REQ-006..011 for requester 1 (full-connect).
REQ-013 RomAddr_o  output  AddrWidth  address to synchronous weight ROM (1-cycle read latency).
REQ-014 RomData_i  input  DataWidth  weight ROM read data.
REQ-015 RdData_o  output  DataWidth  RomData_i passed through combinationally.
REQ-016 Busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, ISSUE; Busy_o shall equal (state == ISSUE).
REQ-018 IDLE with any Req high at edge: latch owner, base address, length counter; go ISSUE; Gnt of owner registered high from next cycle.
REQ-019 Arbitration round-robin: both requests high -> grant the requester not granted last; after reset requester 0 wins first tie.
REQ-020 Single request high -> that requester granted regardless of pointer; pointer updates to the granted requester.
REQ-021 ISSUE cycle k (k = 0..Len): RomAddr_o = base + k modulo 2^AddrWidth (511 + 1 wraps to 0); owner Gnt high.
REQ-022 ISSUE exits to IDLE at the edge ending the cycle with counter zero; Gnt low in the following cycle.
REQ-023 Each ISSUE cycle produces RdValid of the owner exactly one cycle later; RdLast asserted with the beat for k = Len only.
REQ-024 Latency: Req sampled at edge T -> first RomAddr_o in cycle T+1 -> first RdValid in cycle T+2; burst of N beats occupies N ISSUE cycles.
REQ-025 At least one IDLE cycle between consecutive bursts; final RdValid of a burst coincides with that IDLE cycle.
REQ-026 Req, Addr, Len changes during ISSUE ignored; Req dropped before grant -> no grant, no beat.
REQ-027 RomAddr_o holds last issued value in IDLE.
REQ-028 Gnt0_o and Gnt1_o never high together; RdValid0_o and RdValid1_o never high together.

Reset
REQ-029 rstn low: state IDLE, pointer favours requester 0, RomAddr_o = 0, all Gnt/RdValid/RdLast/Busy_o = 0, counters 0, immediately and asynchronously.
REQ-030 Reset mid-burst abandons the burst; pending read beat not delivered after rstn rises.

Structure
REQ-031 Shared package acc_pkg holds AddrWidth/DataWidth/LenWidth defaults and the IDLE/ISSUE state encoding.
REQ-032 Two-way round-robin pick as sub-module wt_rr_pick (requests plus last-grant in, one-hot grant out, combinational).

Verification
REQ-033 Req0 only, Addr0=0x010, Len0=3 -> RomAddr 0x010..0x013 in cycles T+1..T+4, RdValid0 T+2..T+5, RdLast0 only T+5.
REQ-034 Req0 and Req1 high same cycle after reset -> requester 0 burst first, requester 1 granted after one IDLE cycle.
REQ-035 Both held continuously, Len=0 each -> grants alternate 0,1,0,1 with one IDLE cycle between.
REQ-036 Req1, Addr1=0x1FE, Len1=3 -> RomAddr 0x1FE, 0x1FF, 0x000, 0x001.
REQ-037 rstn low in second ISSUE cycle of Len=7 burst -> all outputs 0 same cycle, no RdValid after release, next Req0 grant normal.
REQ-038 Addr0 changed during ISSUE -> issued addresses unaffected; RdData_o equals RomData_i every cycle.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared defaults and state encoding for the accelerator weight-ROM path.
package acc_pkg;

  localparam int unsigned AddrWidthDef = 9;
  localparam int unsigned DataWidthDef = 192;
  localparam int unsigned LenWidthDef  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wt_rr_pick.sv
// Two-way round-robin pick: a tie goes to the requester that did not win last.
module wt_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/wt_rom_arbiter.sv
// Arbitrates burst reads of the weight ROM between the convolution (0) and
// full-connect (1) engines; read beats return one cycle after address issue.
module wt_rom_arbiter
  import acc_pkg::*;
#(
  parameter int unsigned AddrWidth = AddrWidthDef,
  parameter int unsigned DataWidth = DataWidthDef,
  parameter int unsigned LenWidth  = LenWidthDef
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 Req0_i,
  input  logic [AddrWidth-1:0] Addr0_i,
  input  logic [LenWidth-1:0]  Len0_i,
  output logic                 Gnt0_o,
  output logic                 RdValid0_o,
  output logic                 RdLast0_o,
  input  logic                 Req1_i,
  input  logic [AddrWidth-1:0] Addr1_i,
  input  logic [LenWidth-1:0]  Len1_i,
  output logic                 Gnt1_o,
  output logic                 RdValid1_o,
  output logic                 RdLast1_o,
  output logic [AddrWidth-1:0] RomAddr_o,
  input  logic [DataWidth-1:0] RomData_i,
  output logic [DataWidth-1:0] RdData_o,
  output logic                 Busy_o
);

  // Handshake: Req is held until the matching Gnt appears; Gnt is high on
  // every address-issue cycle of the burst, and each issue cycle yields one
  // RdValid beat on the following cycle with RdLast marking the final beat.

  arb_state_e           state_q, state_d;
  logic                 owner_q, owner_d;  // current owner, doubles as round-robin pointer
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic [1:0]           rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic [1:0]           pick_gnt;

  wt_rr_pick u_pick (
    .req_i  ({Req1_i, Req0_i}),
    .last_i (owner_q),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_valid_d = 2'b00;
    rd_last_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req0_i || Req1_i) begin
          state_d = ST_ISSUE;
          owner_d = pick_gnt[1];
          addr_d  = pick_gnt[1] ? Addr1_i : Addr0_i;
          cnt_d   = pick_gnt[1] ? Len1_i : Len0_i;
        end
      end
      ST_ISSUE: begin
        rd_valid_d = owner_q ? 2'b10 : 2'b01;
        rd_last_d  = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + AddrWidth'(1);
          cnt_d  = cnt_q - LenWidth'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b1;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 2'b00;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign Busy_o     = (state_q == ST_ISSUE);
  assign Gnt0_o     = Busy_o && !owner_q;
  assign Gnt1_o     = Busy_o && owner_q;
  assign RomAddr_o  = addr_q;
  assign RdValid0_o = rd_valid_q[0];
  assign RdValid1_o = rd_valid_q[1];
  assign RdLast0_o  = rd_valid_q[0] && rd_last_q;
  assign RdLast1_o  = rd_valid_q[1] && rd_last_q;
  assign RdData_o   = RomData_i;

endmodule

// File: tb/tb_wt_rom_arbiter.sv
// Bench for wt_rom_arbiter: directed scenarios then random traffic, scored
// against a burst-level reference model and an expected-beat queue.
module tb_wt_rom_arbiter;

  localparam int AW = 9;
  localparam int DW = 192;
  localparam int LW = 4;
  localparam int EW = AW + 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [LW-1:0] len0, len1;
  logic          gnt0, gnt1, rv0, rv1, rl0, rl1, busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, rd_data;

  wt_rom_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .Req0_i     (req0),
    .Addr0_i    (addr0),
    .Len0_i     (len0),
    .Gnt0_o     (gnt0),
    .RdValid0_o (rv0),
    .RdLast0_o  (rl0),
    .Req1_i     (req1),
    .Addr1_i    (addr1),
    .Len1_i     (len1),
    .Gnt1_o     (gnt1),
    .RdValid1_o (rv1),
    .RdLast1_o  (rl1),
    .RomAddr_o  (rom_addr),
    .RomData_i  (rom_data),
    .RdData_o   (rd_data),
    .Busy_o     (busy)
  );

  // ---------------- clock and ROM ----------------
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [23:0] w;
    w = {a, 15'((int'(a) * 37 + 5) % 32768)};
    return {8{w}};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];  // {owner, last, address}
  int            m_busy = 0, m_owner = 0, m_left = 0, m_last = 1, flush_to = 0;
  logic [AW-1:0] m_addr = '0;
  logic [1:0]    m_rv = 2'b00;
  logic          m_rl = 1'b0;

  always @(posedge clk or negedge rstn) begin : model
    int            own;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    if (!rstn) begin
      m_busy   <= 0;
      m_owner  <= 0;
      m_left   <= 0;
      m_last   <= 1;
      m_addr   <= '0;
      m_rv     <= 2'b00;
      m_rl     <= 1'b0;
      flush_to <= exp_q.size();
    end else if (m_busy != 0) begin
      m_rv <= (m_owner == 1) ? 2'b10 : 2'b01;
      m_rl <= (m_left == 1);
      if (m_left == 1) m_busy <= 0;
      else begin
        m_addr <= AW'((int'(m_addr) + 1) % 512);
        m_left <= m_left - 1;
      end
    end else begin
      m_rv <= 2'b00;
      m_rl <= 1'b0;
      if (req0 || req1) begin
        own  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
        base = (own == 1) ? addr1 : addr0;
        len  = (own == 1) ? len1 : len0;
        for (int k = 0; k <= int'(len); k++)
          exp_q.push_back({own[0], k == int'(len), AW'((int'(base) + k) % 512)});
        m_owner <= own;
        m_last  <= own;
        m_busy  <= 1;
        m_addr  <= base;
        m_left  <= int'(len) + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int errors = 0, checks = 0, rd_idx = 0, cyc = 0;
  bit done = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (rd_idx < flush_to) rd_idx = flush_to;
    chk1("gnt0", gnt0, m_busy != 0 && m_owner == 0);
    chk1("gnt1", gnt1, m_busy != 0 && m_owner == 1);
    chk1("busy", busy, m_busy != 0);
    chk1("gnt_exclusive", gnt0 && gnt1, 1'b0);
    chka("rom_addr", rom_addr, m_addr);
    chk1("rdvalid0", rv0, m_rv[0]);
    chk1("rdvalid1", rv1, m_rv[1]);
    chk1("rdlast0", rl0, m_rv[0] && m_rl);
    chk1("rdlast1", rl1, m_rv[1] && m_rl);
    chkd("rddata_passthru", rd_data, rom_data);
    if (rv0 || rv1) begin
      if (rd_idx >= exp_q.size()) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got beat rv0=%0b rv1=%0b expected none (t=%0t)", rv0, rv1, $time);
      end else begin
        e = exp_q[rd_idx];
        rd_idx++;
        chk1("beat_owner", rv1, e[EW-1]);
        chk1("beat_last", rl0 || rl1, e[EW-2]);
        chkd("beat_data", rd_data, rom_fn(e[AW-1:0]));
      end
    end
    if (done || cyc > 30000) begin
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
      end
      checks++;
      if (rd_idx != exp_q.size()) begin
        errors++;
        $display("FAIL beats_delivered: got %0d expected %0d", rd_idx, exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- driver ----------------
  bit hold = 1'b0;

  task automatic step();
    @(negedge clk);
    if (m_busy != 0 && m_owner == 0) begin
      if (!hold) req0 = 1'b0;
      addr0 = AW'($urandom_range(0, 511));
      len0  = LW'($urandom_range(0, 15));
    end
    if (m_busy != 0 && m_owner == 1) begin
      if (!hold) req1 = 1'b0;
      addr1 = AW'($urandom_range(0, 511));
      len1  = LW'($urandom_range(0, 15));
    end
  endtask

  task automatic send(input int who, input int a, input int l);
    if (who == 0) begin
      req0 = 1'b1; addr0 = AW'(a); len0 = LW'(l);
    end else begin
      req1 = 1'b1; addr1 = AW'(a); len1 = LW'(l);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (m_busy == 0 && !req0 && !req1 && m_rv == 2'b00) break;
      step();
    end
    step();
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    #1 rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;

    step(); send(0, 'h010, 3); wait_idle();

    rstn = 1'b0; step(); rstn = 1'b1;
    step(); send(0, 'h020, 1); send(1, 'h040, 2); wait_idle();

    hold = 1'b1;
    step(); send(0, 'h080, 0); send(1, 'h0C0, 0);
    repeat (12) step();
    req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    wait_idle();

    step(); send(1, 'h1FE, 3); wait_idle();

    step(); send(0, 'h100, 7);
    for (int i = 0; i < 20 && m_busy == 0; i++) step();
    @(posedge clk);
    #1;
    rstn = 1'b0; req0 = 1'b0;
    step(); step();
    rstn = 1'b1;
    step(); send(0, 'h055, 2); wait_idle();

    for (int i = 0; i < 400; i++) begin
      step();
      if (!req0 && $urandom_range(0, 3) == 0)
        send(0, int'($urandom_range(0, 511)), int'($urandom_range(0, 5)));
      else if (req0 && !(m_busy != 0 && m_owner == 0) && $urandom_range(0, 19) == 0)
        req0 = 1'b0;
      if (!req1 && $urandom_range(0, 3) == 0)
        send(1, int'($urandom_range(0, 511)), int'($urandom_range(0, 5)));
      else if (req1 && !(m_busy != 0 && m_owner == 1) && $urandom_range(0, 19) == 0)
        req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    repeat (3) step();
    done = 1'b1;
  end

endmodule
